sc_stream_decoder: RTL and testbench

Stochastic-to-binary decoder for the SC FIR datapath. It counts the ones in a window of 2^N qualified bitstream bits, then emits the binary count. This is the receive end of the VDC-driven stochastic number generator: VDC plus comparator encode a binary value into a bitstream, and this block recovers it. One window corresponds to one full VDC period.

---
 rtl/sc_stream_decoder.sv | 89 ++++++++
 tb/tb_sc_stream_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a window of 2**N qualified bits.
// Define SC_BIPOLAR_EN for bipolar output (2*ones - LEN, N+2 bits, two's complement).
module sc_stream_decoder #(
  parameter int N = 2,
`ifdef SC_BIPOLAR_EN
  localparam int OW = N + 2
`else
  localparam int OW = N + 1
`endif
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic [OW-1:0] out,
  output logic          out_valid,
  output logic          busy
);

  localparam int LEN = 2 ** N;
  localparam logic [N:0] LAST = (N+1)'(LEN - 1);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [N:0]   acc;
  logic [N:0]   idx;
  logic [N:0]   acc_sum;
  logic         done;

`ifdef SC_BIPOLAR_EN
  function automatic logic signed [OW-1:0] encode(input logic [N:0] cnt);
    logic signed [OW-1:0] dbl;
    dbl = {cnt, 1'b0};
    return dbl - OW'(LEN);
  endfunction
`else
  function automatic logic [OW-1:0] encode(input logic [N:0] cnt);
    return cnt;
  endfunction
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // start has priority over completion; a one-bit window closes on its start cycle
  always_comb begin
    state_nxt = state;
    if (start)
      state_nxt = (bit_valid && LEN == 1) ? IDLE : ACCUM;
    else if (state == ACCUM && bit_valid && idx == LAST)
      state_nxt = IDLE;
  end

  always_comb begin
    busy = (state == ACCUM);
    done = 1'b0;
    if (bit_valid) begin
      if (start) done = (LEN == 1);
      else       done = (state == ACCUM) && (idx == LAST);
    end
  end

  assign acc_sum = (start ? '0 : acc) + (N+1)'(bit_in);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      idx       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= done;
      if (done)
        out <= encode(acc_sum);
      if (start) begin
        acc <= (N+1)'(bit_valid & bit_in);
        idx <= (N+1)'(bit_valid);
      end else if (state == ACCUM && bit_valid && !done) begin
        acc <= acc_sum;
        idx <= idx + (N+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder (N=2); a queue-based window model is compared every cycle.
module tb_sc_stream_decoder;

  localparam int N   = 2;
  localparam int LEN = 4;
`ifdef SC_BIPOLAR_EN
  localparam int OW  = N + 2;
`else
  localparam int OW  = N + 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic [OW-1:0] out;
  logic          out_valid;
  logic          busy;

  int checks = 0;
  int errors = 0;

  sc_stream_decoder #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .out(out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  // Expected encoding of a ones count for the current build
  function automatic int enc(input int ones);
`ifdef SC_BIPOLAR_EN
    return (2 * ones - LEN) & ((1 << OW) - 1);
`else
    return ones;
`endif
  endfunction

  // Model: a window is a list of collected bits; it closes once LEN are held
  bit open = 1'b0;
  int win[$];
  int exp_out = 0;
  bit exp_vld = 1'b0;
  bit exp_busy = 1'b0;

  always @(posedge clock) begin
    int ones;
    exp_vld = 1'b0;
    if (reset) begin
      open = 1'b0;
      win.delete();
      exp_out = 0;
    end else if (start || open) begin
      if (start) win.delete();
      open = 1'b1;
      if (bit_valid) win.push_back(int'(bit_in));
      if (win.size() == LEN) begin
        ones = 0;
        foreach (win[i]) ones += win[i];
        exp_out = enc(ones);
        exp_vld = 1'b1;
        open = 1'b0;
        win.delete();
      end
    end
    exp_busy = open;
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  bit chk_en = 1'b0;
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_out", int'(out), exp_out);
      check("model_out_valid", int'(out_valid), int'(exp_vld));
      check("model_busy", int'(busy), int'(exp_busy));
    end
  end

  task automatic drive(input logic s, input logic v, input logic b);
    start = s; bit_valid = v; bit_in = b;
    @(posedge clock);
    #1;
  endtask

  task automatic run_window(input logic [3:0] bits);
    drive(1'b1, 1'b1, bits[3]);
    drive(1'b0, 1'b1, bits[2]);
    drive(1'b0, 1'b1, bits[1]);
    drive(1'b0, 1'b1, bits[0]);
  endtask

  initial begin
    // Reset held two cycles with live input bits
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    chk_en = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    check("reset_out", int'(out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1);
    check("idle_no_start_busy", int'(busy), 0);
    check("idle_no_start_out", int'(out), 0);

    // Basic window 1,0,1,1
    drive(1'b1, 1'b1, 1'b1);
    check("basic_busy_rise", int'(busy), 1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    check("basic_no_early_valid", int'(out_valid), 0);
    drive(1'b0, 1'b1, 1'b1);
`ifndef SC_BIPOLAR_EN
    check("basic_out", int'(out), 3);
`endif
    check("basic_out_valid", int'(out_valid), 1);
    check("basic_busy_fall", int'(busy), 0);
    drive(1'b0, 1'b0, 1'b0);
    check("basic_pulse_once", int'(out_valid), 0);

    // Gapped window 1,1,1,1
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("gap_stall_no_valid", int'(out_valid), 0);
    check("gap_stall_busy", int'(busy), 1);
    drive(1'b0, 1'b1, 1'b1);
`ifndef SC_BIPOLAR_EN
    check("gap_out", int'(out), 4);
`endif
    check("gap_out_valid", int'(out_valid), 1);

    // Abort after 1,1 then window 0,0,0,1
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    check("abort_no_valid", int'(out_valid), 0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    check("abort_no_valid_late", int'(out_valid), 0);
    drive(1'b0, 1'b1, 1'b1);
`ifndef SC_BIPOLAR_EN
    check("abort_out", int'(out), 1);
`endif
    check("abort_out_valid", int'(out_valid), 1);

    // Back-to-back: start in the out_valid cycle, bits 1,1,0,0
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
`ifndef SC_BIPOLAR_EN
    check("b2b_out_held", int'(out), 1);
`endif
    drive(1'b0, 1'b1, 1'b0);
`ifndef SC_BIPOLAR_EN
    check("b2b_out", int'(out), 2);
`endif
    check("b2b_out_valid", int'(out_valid), 1);

    // Mid-window reset after three bits
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_out", int'(out), 0);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1);
    check("midrst_no_valid", int'(out_valid), 0);
    check("midrst_out_kept", int'(out), 0);

`ifdef SC_BIPOLAR_EN
    run_window(4'b1111);
    check("bip_plus4", int'(out), 4'b0100);
    run_window(4'b0000);
    check("bip_minus4", int'(out), 4'b1100);
    run_window(4'b1010);
    check("bip_zero", int'(out), 0);
`else
    run_window(4'b0110);
    check("uni_two", int'(out), 2);
    run_window(4'b0000);
    check("uni_zero", int'(out), 0);
`endif
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
